// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter
// Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ
// requesters. Each requester raises req_valid with a single read or write
// command. The arbiter runs one AXI4-Lite transaction at a time and pulses
// req_done to the requester it served.
//
// Ports:
//   ACLK, ARESET              clock, asynchronous active-high reset
//   req_valid/req_write       per-requester command request and direction
//   req_addr/wdata/wstrb      packed per-requester command fields
//   req_done                  one-cycle completion pulse to the served requester
//   rsp_rdata/rsp_resp        read data / BRESP-RRESP, held until the next capture
//   M_AXI_*                   AXI4-Lite master port
//   dbg_state/dbg_rr_ptr      FSM state and round-robin pointer, for observation
//
// Handshake rule: a channel transfers on the rising edge where VALID and READY
// are both high. VALID, address and data do not change until that edge, and
// VALID drops in the cycle that follows it.
module axil_reg_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic [1:0]                         rsp_resp,
    output logic [ADDR_WIDTH-1:0]              M_AXI_AWADDR,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic                               M_AXI_AWVALID,
    input  logic                               M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]              M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
    output logic                               M_AXI_WVALID,
    input  logic                               M_AXI_WREADY,
    input  logic [1:0]                         M_AXI_BRESP,
    input  logic                               M_AXI_BVALID,
    output logic                               M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]              M_AXI_ARADDR,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]              M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [2:0]                         dbg_state,
    output logic [$clog2(NUM_REQ)-1:0]         dbg_rr_ptr
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state_q,     state_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]      grant_q,     grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0]     wstrb_q,     wstrb_d;
    logic                  aw_done_q,   aw_done_d;
    logic                  w_done_q,    w_done_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  bready_q,    bready_d;
    logic                  rready_q,    rready_d;
    logic [NUM_REQ-1:0]    req_done_q,  req_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q,  rsp_resp_d;

    // Round-robin pick: first set req_valid bit at or above rr_ptr, wrapping.
    logic             found;
    logic [PTR_W-1:0] pick;
    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_w;
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = PTR_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        req_done_d  = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    // Registers are word aligned, so the byte offset is dropped.
                    addr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
                    wdata_d = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d = req_wstrb[pick*STRB_W +: STRB_W];
                    if (req_write[pick]) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently, in either order.
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d            = 1'b0;
                    rsp_resp_d          = M_AXI_BRESP;
                    req_done_d[grant_q] = 1'b1;
                    state_d             = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d            = 1'b0;
                    rsp_rdata_d         = M_AXI_RDATA;
                    rsp_resp_d          = M_AXI_RRESP;
                    req_done_d[grant_q] = 1'b1;
                    state_d             = S_DONE;
                end
            end
            S_DONE: begin
                rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            req_done_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            req_done_q  <= req_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign req_done      = req_done_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Testbench for axil_reg_arbiter with a 4-register AXI4-Lite slave model
// whose per-channel ready/valid delays and error response are programmable.
module tb_axil_reg_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int EW = NR + 2 + DW;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_write = '0;
    logic [NR*AW-1:0]   req_addr  = '0;
    logic [NR*DW-1:0]   req_wdata = '0;
    logic [NR*4-1:0]    req_wstrb = '0;
    logic [NR-1:0]      req_done;
    logic [31:0]        rsp_rdata;
    logic [1:0]         rsp_resp;
    logic [AW-1:0]      M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]         M_AXI_AWPROT, M_AXI_ARPROT;
    logic               M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0]        M_AXI_WDATA;
    logic [3:0]         M_AXI_WSTRB;
    logic               M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]         M_AXI_BRESP;
    logic               M_AXI_BVALID, M_AXI_BREADY;
    logic               M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0]        M_AXI_RDATA;
    logic [1:0]         M_AXI_RRESP;
    logic               M_AXI_RVALID, M_AXI_RREADY;
    logic [2:0]         dbg_state;
    logic [0:0]         dbg_rr_ptr;

    axil_reg_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- slave model ----------------
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic s_err = 1'b0;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic [3:0]  s_awaddr, s_wstrb;
    logic [31:0] s_wdata, s_rdata;
    logic [31:0] s_regs [4];

    assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_wait >= aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_wait >= w_delay);
    assign M_AXI_BVALID  = b_pend && (b_wait >= b_delay);
    assign M_AXI_BRESP   = s_err ? 2'b10 : 2'b00;
    assign M_AXI_ARREADY = M_AXI_ARVALID && !r_pend && (ar_wait >= ar_delay);
    assign M_AXI_RVALID  = r_pend && (r_wait >= r_delay);
    assign M_AXI_RRESP   = s_err ? 2'b10 : 2'b00;
    assign M_AXI_RDATA   = s_rdata;

    always @(posedge ACLK or posedge ARESET) begin : slave
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  st;
        if (ARESET) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
            for (int i = 0; i < 4; i++) s_regs[i] <= '0;
        end else begin
            if (M_AXI_AWVALID && !aw_got) begin
                if (M_AXI_AWREADY) begin
                    aw_got <= 1'b1; s_awaddr <= M_AXI_AWADDR; aw_wait <= 0;
                end else aw_wait <= aw_wait + 1;
            end
            if (M_AXI_WVALID && !w_got) begin
                if (M_AXI_WREADY) begin
                    w_got <= 1'b1; s_wdata <= M_AXI_WDATA; s_wstrb <= M_AXI_WSTRB; w_wait <= 0;
                end else w_wait <= w_wait + 1;
            end
            a  = M_AXI_AWREADY ? M_AXI_AWADDR : s_awaddr;
            d  = M_AXI_WREADY ? M_AXI_WDATA : s_wdata;
            st = M_AXI_WREADY ? M_AXI_WSTRB : s_wstrb;
            if ((aw_got || M_AXI_AWREADY) && (w_got || M_AXI_WREADY)) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) s_regs[a[3:2]][b*8 +: 8] <= d[b*8 +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_wait <= 0;
            end
            if (b_pend) begin
                if (M_AXI_BVALID && M_AXI_BREADY) b_pend <= 1'b0;
                else b_wait <= b_wait + 1;
            end
            if (M_AXI_ARVALID && !r_pend) begin
                if (M_AXI_ARREADY) begin
                    r_pend <= 1'b1; r_wait <= 0; ar_wait <= 0;
                    s_rdata <= s_regs[M_AXI_ARADDR[3:2]];
                end else ar_wait <= ar_wait + 1;
            end
            if (r_pend) begin
                if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 1'b0;
                else r_wait <= r_wait + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0] model_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every req_done pulse consumes one expected entry.
    always @(negedge ACLK) begin
        logic [EW-1:0] e;
        if (!ARESET && req_done !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got %0h expected none at %0t", req_done, $time);
            end else begin
                e = exp_q.pop_front();
                check("done_mask", 64'(req_done), 64'(e[EW-1 -: NR]));
                check("rsp_resp", 64'(rsp_resp), 64'(e[33:32]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
            end
        end
    end

    // Channel protocol monitor: VALID holds until handshake and drops after it;
    // BREADY/RREADY hold while the response is outstanding.
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic p_br = 0, p_bv = 0, p_rr = 0, p_rv = 0, p_rst = 1;
    logic [3:0]  p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0;
    always @(negedge ACLK) begin
        if (!ARESET && !p_rst) begin
            if (p_awv && p_awr) check("awvalid_drop", 64'(M_AXI_AWVALID), 64'(0));
            else if (p_awv) begin
                check("awvalid_hold", 64'(M_AXI_AWVALID), 64'(1));
                check("awaddr_stable", 64'(M_AXI_AWADDR), 64'(p_awaddr));
            end
            if (p_wv && p_wr) check("wvalid_drop", 64'(M_AXI_WVALID), 64'(0));
            else if (p_wv) begin
                check("wvalid_hold", 64'(M_AXI_WVALID), 64'(1));
                check("wdata_stable", 64'(M_AXI_WDATA), 64'(p_wdata));
            end
            if (p_arv && p_arr) check("arvalid_drop", 64'(M_AXI_ARVALID), 64'(0));
            else if (p_arv) begin
                check("arvalid_hold", 64'(M_AXI_ARVALID), 64'(1));
                check("araddr_stable", 64'(M_AXI_ARADDR), 64'(p_araddr));
            end
            if (p_br && !p_bv) check("bready_hold", 64'(M_AXI_BREADY), 64'(1));
            if (p_rr && !p_rv) check("rready_hold", 64'(M_AXI_RREADY), 64'(1));
        end
        p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        p_wv = M_AXI_WVALID; p_wr = M_AXI_WREADY; p_wdata = M_AXI_WDATA;
        p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
        p_br = M_AXI_BREADY; p_bv = M_AXI_BVALID; p_rr = M_AXI_RREADY; p_rv = M_AXI_RVALID;
        p_rst = ARESET;
    end

    // ---------------- driver tasks ----------------
    task automatic set_delays(input int awd, input int wdd, input int bd, input int ard,
                              input int rd, input logic err);
        aw_delay = awd; w_delay = wdd; b_delay = bd; ar_delay = ard; r_delay = rd; s_err = err;
    endtask

    // Called just after a negedge with the DUT in IDLE. The IDLE cycle that
    // samples the request counts as cycle 1 of the latency.
    task automatic do_cmd(input int r, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] exp_resp,
                          input logic [31:0] exp_rd, input int exp_cyc);
        logic [NR-1:0] m;
        int cyc;
        logic seen;
        m = '0;
        m[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = wd;
        req_wstrb[r*4 +: 4] = ws;
        req_valid[r] = 1'b1;
        if (!wr) model_rdata = exp_rd;
        exp_q.push_back({m, exp_resp, model_rdata});
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge ACLK);
            cyc++;
            if (req_done[r]) seen = 1'b1;
        end
        check("latency", 64'(seen ? cyc : -1), 64'(exp_cyc));
        req_valid[r] = 1'b0;
        @(negedge ACLK);
        check("idle_after_done", 64'(dbg_state), 64'(0));
    endtask

    task automatic check_reset_outs(input string t);
        check({t, "_valid_ready"}, 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                        M_AXI_BREADY, M_AXI_RREADY}), 64'(0));
        check({t, "_req_done"}, 64'(req_done), 64'(0));
        check({t, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({t, "_rsp_resp"}, 64'(rsp_resp), 64'(0));
        check({t, "_addr"}, 64'({M_AXI_AWADDR, M_AXI_ARADDR}), 64'(0));
        check({t, "_wdata_wstrb"}, 64'({M_AXI_WDATA, M_AXI_WSTRB}), 64'(0));
        check({t, "_state"}, 64'(dbg_state), 64'(0));
        check({t, "_rr_ptr"}, 64'(dbg_rr_ptr), 64'(0));
    endtask

    // ---------------- test ----------------
    typedef struct {
        int          r;
        logic        wr;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          awd, wdd, bd, ard, rd;
        logic        err;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          cyc;
    } vec_t;

    vec_t tbl [10];
    logic [31:0] ref_mem [4];

    initial begin
        int n, cyc, last, waited;
        logic [1:0] ri;
        logic [31:0] rv;
        int awd, wdd, bd, ard, rd, r;

        tbl[0] = '{0, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 4};
        tbl[1] = '{0, 1'b0, 4'h4, 32'h0,       4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'hDEADBEEF, 4};
        tbl[2] = '{1, 1'b1, 4'hC, 32'h55,      4'hF, 0, 3, 0, 0, 0, 1'b0, 2'b00, 32'h0, 7};
        tbl[3] = '{1, 1'b0, 4'hC, 32'h0,       4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h55, 4};
        tbl[4] = '{0, 1'b1, 4'h8, 32'hA5A5A5A5, 4'h3, 0, 0, 5, 0, 0, 1'b0, 2'b00, 32'h0, 9};
        tbl[5] = '{0, 1'b0, 4'h8, 32'h0,       4'h0, 0, 0, 0, 0, 5, 1'b0, 2'b00, 32'h0000A5A5, 9};
        tbl[6] = '{1, 1'b0, 4'h5, 32'h0,       4'h0, 0, 0, 0, 2, 0, 1'b0, 2'b00, 32'hDEADBEEF, 6};
        tbl[7] = '{0, 1'b0, 4'h0, 32'h0,       4'h0, 0, 0, 0, 0, 0, 1'b1, 2'b10, 32'h0, 4};
        tbl[8] = '{1, 1'b1, 4'h0, 32'h11223344, 4'h4, 3, 0, 0, 0, 0, 1'b1, 2'b10, 32'h0, 7};
        tbl[9] = '{0, 1'b0, 4'h0, 32'h0,       4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h00220000, 4};

        // Reset state
        repeat (3) @(negedge ACLK);
        check_reset_outs("reset");
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);

        // Directed table: write/read, channel skew, backpressure, alignment, errors
        foreach (tbl[i]) begin
            set_delays(tbl[i].awd, tbl[i].wdd, tbl[i].bd, tbl[i].ard, tbl[i].rd, tbl[i].err);
            do_cmd(tbl[i].r, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ws,
                   tbl[i].resp, tbl[i].rdata, tbl[i].cyc);
        end

        // Random write/read-back pairs with random channel delays
        ref_mem[0] = 32'h00220000; ref_mem[1] = 32'hDEADBEEF;
        ref_mem[2] = 32'h0000A5A5; ref_mem[3] = 32'h00000055;
        for (int k = 0; k < 6; k++) begin
            r   = $urandom_range(0, 1);
            ri  = 2'($urandom_range(0, 3));
            rv  = $urandom;
            awd = $urandom_range(0, 3); wdd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
            ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            set_delays(awd, wdd, bd, 0, 0, 1'b0);
            do_cmd(r, 1'b1, {ri, 2'b00}, rv, 4'hF, 2'b00, 32'h0, 4 + ((awd > wdd) ? awd : wdd) + bd);
            ref_mem[ri] = rv;
            set_delays(0, 0, 0, ard, rd, 1'b0);
            do_cmd(1 - r, 1'b0, {ri, 2'b00}, 32'h0, 4'h0, 2'b00, ref_mem[ri], 4 + ard + rd);
        end

        // Leave rr_ptr at 1 so the reset below has something to clear
        set_delays(0, 0, 0, 0, 0, 1'b0);
        do_cmd(0, 1'b0, 4'h4, 32'h0, 4'h0, 2'b00, ref_mem[1], 4);

        // Reset in WR_RESP: outputs clear asynchronously, no req_done
        set_delays(0, 0, 20, 0, 0, 1'b0);
        req_write[0] = 1'b1;
        req_addr[0 +: AW] = 4'h4;
        req_wdata[0 +: DW] = 32'h77;
        req_wstrb[0 +: 4] = 4'hF;
        req_valid[0] = 1'b1;
        waited = 0;
        while (!M_AXI_BREADY && waited < 20) begin
            @(negedge ACLK);
            waited++;
        end
        check("reach_wr_resp", 64'(M_AXI_BREADY), 64'(1));
        #2 ARESET = 1'b1;
        #1 check_reset_outs("mid_reset");
        @(negedge ACLK);
        req_valid = '0;
        set_delays(0, 0, 0, 0, 0, 1'b0);
        @(negedge ACLK);
        ARESET = 1'b0;
        model_rdata = '0;
        @(negedge ACLK);
        do_cmd(1, 1'b0, 4'h4, 32'h0, 4'h0, 2'b00, 32'h0, 4);

        // Contention: both requesters hold write requests; expect 0,1,0,1
        req_write = '1;
        req_addr  = {4'h8, 4'h0};
        req_wdata = {32'h2, 32'h1};
        req_wstrb = {4'hF, 4'hF};
        exp_q.push_back({2'b01, 2'b00, model_rdata});
        exp_q.push_back({2'b10, 2'b00, model_rdata});
        exp_q.push_back({2'b01, 2'b00, model_rdata});
        exp_q.push_back({2'b10, 2'b00, model_rdata});
        req_valid = '1;
        n = 0; cyc = 0; last = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge ACLK);
            cyc++;
            if (req_done !== '0) begin
                n++;
                if (n > 1) check("contention_spacing", 64'(cyc - last), 64'(4));
                last = cyc;
                if (n == 4) req_valid = '0;
            end
        end
        req_valid = '0;
        check("contention_count", 64'(n), 64'(4));
        @(negedge ACLK);
        do_cmd(0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 32'h1, 4);
        do_cmd(1, 1'b0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h2, 4);

        repeat (5) @(negedge ACLK);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_arbiter.md
# axil_reg_arbiter

Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ internal requesters. It drives the 4-register AXI4-Lite slave (S00_AXI, 32-bit registers at byte offsets 0x0–0xC). Each requester issues single read or write commands through a simple valid/done interface. The block serialises those commands into AXI4-Lite transactions, one outstanding transaction at a time, and returns read data and response codes to the requester that issued the command.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2–8)
- ADDR_WIDTH, 4, AXI byte-address width
- DATA_WIDTH, 32, AXI data width (fixed at 32)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command request; held until that requester's req_done
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*32  write data, packed
- req_wstrb  in  NUM_REQ*4  write strobes, packed
- req_done  out  NUM_REQ  one-cycle pulse to the served requester
- rsp_rdata  out  32  read data; valid with req_done when it is a read
- rsp_resp  out  2  BRESP/RRESP of the completed transaction; valid with req_done
- M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID / M_AXI_AWREADY; M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID / M_AXI_WREADY; M_AXI_BRESP, M_AXI_BVALID / M_AXI_BREADY; M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID / M_AXI_ARREADY; M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID / M_AXI_RREADY
  - Standard AXI4-Lite master signals with standard widths; ADDR_WIDTH for addresses.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch that requester's addr, wdata, wstrb and write into registers.
  - Go to WR if write=1, otherwise RD_ADDR.
  - With no request, stay in IDLE.
- Address handling: latched address with bits[1:0] forced to 0. AWPROT/ARPROT = 3'b000.
- WR:
  - AWVALID and WVALID are both asserted on entry.
  - Each channel is tracked independently (aw_done, w_done flags). Each valid drops in the cycle after its own handshake.
  - When both handshakes have occurred (same or different cycles), go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP into rsp_resp and go to DONE.
- RD_ADDR: ARVALID=1. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA into rsp_rdata and RRESP into rsp_resp, then go to DONE.
- DONE:
  - req_done[grant]=1 for exactly one cycle.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - Next state is IDLE.
- Requesters deassert req_valid at the edge ending their DONE cycle. A req_valid still high in IDLE is treated as a new command.
- req_valid changes for non-granted requesters during a transaction have no effect until the next IDLE.
- SLVERR/DECERR responses are passed through in rsp_resp with no retry.
- rsp_rdata and rsp_resp hold their value until the next capture.
- On a write, rsp_rdata is unchanged.

## Timing
- Reset values: FSM=IDLE, rr_ptr=0, and all of the following are 0: AWVALID, WVALID, ARVALID, BREADY, RREADY, req_done, rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB.
- ARESET asserted mid-transaction:
  - All outputs go to their reset values immediately (asynchronously).
  - No req_done is issued; the interrupted command is lost.
  - The slave shares the same reset.
- Grant sampling: a request sampled in IDLE at edge k causes AW/W/ARVALID to be high in cycle k+1.
- Best-case write: IDLE (1) + WR (1) + WR_RESP (1) + DONE (1) = 4 cycles from request sampling to req_done. This assumes AWREADY and WREADY in the first WR cycle and BVALID in the first WR_RESP cycle. Read best case is also 4 cycles.
- Throughput: back-to-back commands start a new transaction every 4 cycles at best, since IDLE always takes one cycle.
- All VALIDs stay asserted until their handshake; address and data are stable while a VALID is high.
- BREADY and RREADY are high only in WR_RESP and RD_DATA respectively.
- Arbitration is evaluated only in IDLE. Grant order is starvation-free: any pending requester is served within NUM_REQ grants.

## Test plan
- Single write, then read: req0 writes 0xDEADBEEF to 0x4 with strb 0xF; req0 then reads 0x4. Required: req_done pulses once per command, rsp_rdata=0xDEADBEEF, rsp_resp=0, and each command takes 4 cycles with a zero-wait slave.
- Contention: req0 and req1 both keep requesting writes of 0x1 and 0x2 to addresses 0x0 and 0x8 continuously. Required: grant order 0,1,0,1; read-back of 0x0=0x1 and 0x8=0x2.
- Channel skew: slave asserts AWREADY 3 cycles before WREADY on a write of 0x55 to 0xC. Required: AWVALID drops after its handshake, WVALID holds until WREADY, exactly one req_done, and read-back is 0x55.
- Backpressure: BVALID delayed 5 cycles, then RVALID delayed 5 cycles. Required: BREADY/RREADY held high throughout the wait, and req_done arrives exactly 1 cycle after each handshake.
- Error pass-through: slave returns SLVERR on a read. Required: rsp_resp=2'b10 with req_done, no retry, and the FSM returns to IDLE.
- Reset mid-write: assert ARESET while in WR_RESP. Required: all VALID/READY signals and req_done drop to 0 immediately, and rr_ptr=0. After reset releases, a new req1 read completes normally.
